// File: rtl/led_drv_pkg.sv
// ---------------------------------------------------------------------------
// led_drv_pkg
//
// Shared constants, types and helpers for the LED fade driver.
//
//   LEVEL_W          brightness level width; the PWM period is 2**LEVEL_W clocks
//   MAX_LEVEL        highest brightness level (fully on)
//   level_t          one channel's brightness level
//   target_level()   level a channel settles at for a given on/off request
//
// Build option: LED_FADE_EN (see led_fade_driver) changes how levels move,
// but not anything in this package.
// ---------------------------------------------------------------------------
package led_drv_pkg;

  localparam int LEVEL_W   = 4;
  localparam int MAX_LEVEL = 2**LEVEL_W - 1;

  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t LEVEL_MAX = level_t'(MAX_LEVEL);
  localparam level_t LEVEL_MIN = '0;

  // An "on" request settles at full brightness, an "off" request at dark.
  function automatic level_t target_level(input logic req);
    return req ? LEVEL_MAX : LEVEL_MIN;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// ---------------------------------------------------------------------------
// led_fade_channel
//
// One LED channel: holds the brightness level and turns it into a PWM pin.
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   req        in   registered on/off request for this LED
//   step_tick  in   one-cycle pulse; the level moves one step toward the
//                   target on this pulse (fade build only)
//   pwm_cnt    in   shared free-running PWM phase counter
//   pwm_out    out  registered PWM drive, active high
//   at_target  out  level currently equals target_level(req)
//
// Build option LED_FADE_EN:
//   defined   - level ramps by one step per step_tick, saturating at both
//               ends; a request reversal simply turns the ramp around from
//               the current level.
//   undefined - level follows target_level(req) every cycle (no ramp);
//               step_tick is ignored.
// ---------------------------------------------------------------------------
module led_fade_channel
  import led_drv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               step_tick,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               pwm_out,
  output logic               at_target
);

  level_t level_q;
  level_t level_d;
  logic   pwm_q;
  logic   pwm_d;

`ifdef LED_FADE_EN
  // Move one step toward the requested end on each tick. The explicit end
  // checks keep the level from wrapping past 0 or MAX_LEVEL.
  always_comb begin
    level_d = level_q;
    if (step_tick) begin
      if (req && (level_q != LEVEL_MAX)) begin
        level_d = level_q + level_t'(1);
      end else if (!req && (level_q != LEVEL_MIN)) begin
        level_d = level_q - level_t'(1);
      end
    end
  end
`else
  // Without fading the level snaps straight to its end value.
  logic unused_step_tick;
  assign unused_step_tick = step_tick;

  always_comb begin
    level_d = target_level(req);
  end
`endif

  // Level MAX must be solid on, but "level > pwm_cnt" alone would leave one
  // dark cycle per period when pwm_cnt == MAX; hence the explicit MAX term.
  always_comb begin
    pwm_d = (level_q == LEVEL_MAX) || (level_q > pwm_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= LEVEL_MIN;
      pwm_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign at_target = (level_q == target_level(req));

endmodule

// File: rtl/led_fade_driver.sv
// ---------------------------------------------------------------------------
// led_fade_driver
//
// Sits between the Nios II LED PIO export and the board LED pins. Software
// keeps writing plain on/off bits; each LED is driven with a 2**LEVEL_W-level
// PWM whose brightness ramps linearly toward fully on / fully off whenever
// its bit changes.
//
// Parameters
//   STEP_CYCLES  clocks per fade step (>= 2); 50000 at 50 MHz = 1 ms/step
//   NUM_LEDS     number of LED channels
//
// Ports
//   clk          in   system clock (same net as the Nios II clk_clk)
//   rst_n        in   synchronous active-low reset
//   led_in       in   on/off request word, already synchronous to clk
//   led_output   out  registered PWM drive to the LED pins, active high
//   busy         out  registered; high while any level differs from target
//
// Build option LED_FADE_EN:
//   defined   - step prescaler is built, levels ramp one step per
//               STEP_CYCLES clocks, busy reports ramps in progress.
//   undefined - no prescaler; led_output is led_in delayed by three clocks
//               (request, level, output registers); busy is tied to 0.
//
// Timing notes (fade build): step_cnt restarts at 0 out of reset, so the
// first level step lands STEP_CYCLES clocks after release. A level change
// reaches the pin one clock later.
// ---------------------------------------------------------------------------
module led_fade_driver
  import led_drv_pkg::*;
#(
  parameter int STEP_CYCLES = 50000,
  parameter int NUM_LEDS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_output,
  output logic                busy
);

  logic [NUM_LEDS-1:0] led_req_q;
  logic [LEVEL_W-1:0]  pwm_cnt_q;
  logic [LEVEL_W-1:0]  pwm_cnt_d;
  logic                step_tick;
  logic [NUM_LEDS-1:0] pwm_out;
  logic [NUM_LEDS-1:0] at_target;

  // -------------------------------------------------------------------------
  // Input register and shared PWM phase counter. The counter is exactly
  // LEVEL_W bits wide, so the MAX_LEVEL -> 0 wrap is the natural overflow.
  // -------------------------------------------------------------------------
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_req_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      led_req_q <= led_in;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

`ifdef LED_FADE_EN
  // -------------------------------------------------------------------------
  // Step prescaler: counts 0..STEP_CYCLES-1; step_tick marks the last count.
  // -------------------------------------------------------------------------
  localparam int STEP_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  logic [STEP_W-1:0] step_cnt_q;
  logic [STEP_W-1:0] step_cnt_d;
  logic              busy_q;
  logic              busy_d;

  assign step_tick = (step_cnt_q == STEP_LAST);

  always_comb begin
    step_cnt_d = step_cnt_q + STEP_W'(1);
    if (step_tick) begin
      step_cnt_d = '0;
    end
  end

  // busy compares against the current request, so it drops one clock after
  // the last channel lands on its target.
  always_comb begin
    busy_d = ~(&at_target);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  // Levels jump straight to target, so there is never anything in flight.
  localparam int unused_step_cycles = STEP_CYCLES;

  logic unused_at_target;
  assign unused_at_target = ^at_target;

  assign step_tick = 1'b0;
  assign busy      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Channels: fully independent; channels sharing a request and start level
  // stay aligned because they share step_tick and pwm_cnt.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_fade_channel u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (led_req_q[i]),
      .step_tick (step_tick),
      .pwm_cnt   (pwm_cnt_q),
      .pwm_out   (pwm_out[i]),
      .at_target (at_target[i])
    );
  end

  assign led_output = pwm_out;

endmodule

// File: tb/tb_led_fade_driver.sv
// ---------------------------------------------------------------------------
// tb_led_fade_driver
//
// Directed bench for led_fade_driver with STEP_CYCLES = 4. Expected values are
// closed-form: after a release at edge 0 with request on, the level after
// edge m is min(15, m/4); the pin after edge m reflects the level and PWM
// phase after edge m-1, and the PWM phase after edge m is m mod 16.
// Builds with or without LED_FADE_EN; each build checks its own behaviour.
// ---------------------------------------------------------------------------
module tb_led_fade_driver;

  localparam int STEP = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] led_in;
  logic [7:0] led_output;
  logic       busy;

  int total;
  int bad;

  led_fade_driver #(
    .STEP_CYCLES (STEP),
    .NUM_LEDS    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .led_output (led_output),
    .busy       (busy)
  );

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- drivers
  // Hold reset for 'hold' edges, then release with the given request word.
  // The edge after this task returns is edge m=1 of the new run.
  task automatic reset_release(input int hold, input logic [7:0] pattern);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n  = 1'b1;
    led_in = pattern;
  endtask

`ifdef LED_FADE_EN
  // Level after edge m of a ramp released with the request on.
  function automatic int lvl_up(input int m);
    int l;
    l = m / STEP;
    return (l > 15) ? 15 : l;
  endfunction

  // Same ramp, but request dropped right after edge 32 (level 8).
  function automatic int lvl_rev(input int m);
    int l;
    if (m <= 32) return lvl_up(m);
    l = 8 - (m - 32) / STEP;
    return (l < 0) ? 0 : l;
  endfunction

  // Pin value after edge m given the level after edge m-1.
  function automatic logic pin_exp(input int lvl, input int m);
    int p;
    p = (m - 1) % 16;
    return (lvl == 15) || (lvl > p);
  endfunction

  // ------------------------------------------------------------- fade tests
  task automatic test_reset();
    logic eb;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (led_output !== 8'h00) begin
        bad++;
        $display("FAIL reset_out c=%0d got=%h exp=00", c, led_output);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 1; m <= 3; m++) begin
      @(posedge clk); #1;
      eb = (m >= 2);
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL release_busy m=%0d got=%b exp=%b", m, busy, eb);
      end
      total++;
      if (led_output !== 8'h00) begin
        bad++;
        $display("FAIL release_out m=%0d got=%h exp=00", m, led_output);
      end
    end
  endtask

  task automatic test_ramp_up();
    logic e;
    logic eb;
    int   duty;
    int   prev_duty;
    reset_release(2, 8'h01);
    duty      = 0;
    prev_duty = 0;
    for (int m = 1; m <= 80; m++) begin
      @(posedge clk); #1;
      e  = pin_exp(lvl_up(m - 1), m);
      eb = (m >= 2) && (lvl_up(m - 1) != 15);
      total++;
      if (led_output !== {7'b0, e}) begin
        bad++;
        $display("FAIL ramp_up_out m=%0d got=%h exp=%h", m, led_output, {7'b0, e});
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL ramp_up_busy m=%0d got=%b exp=%b", m, busy, eb);
      end
      if (led_output[0] === 1'b1) duty++;
      if (m % 16 == 0) begin
        if (m > 16) begin
          total++;
          if (duty < prev_duty) begin
            bad++;
            $display("FAIL ramp_up_duty m=%0d got=%0d prev=%0d", m, duty, prev_duty);
          end
        end
        prev_duty = duty;
        duty      = 0;
      end
    end
    total++;
    if (prev_duty != 16) begin
      bad++;
      $display("FAIL ramp_up_full_duty got=%0d exp=16", prev_duty);
    end
  endtask

  task automatic test_reversal();
    logic e;
    logic eb;
    logic req_prev;
    int   l;
    reset_release(2, 8'h01);
    for (int m = 1; m <= 80; m++) begin
      @(posedge clk); #1;
      l        = lvl_rev(m - 1);
      req_prev = (m - 1 >= 1) && (m - 1 <= 32);
      e        = pin_exp(l, m);
      eb       = req_prev ? (l != 15) : (l != 0);
      total++;
      if (led_output !== {7'b0, e}) begin
        bad++;
        $display("FAIL reversal_out m=%0d got=%h exp=%h", m, led_output, {7'b0, e});
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL reversal_busy m=%0d got=%b exp=%b", m, busy, eb);
      end
      if (m == 32) led_in = 8'h00;
    end
  endtask

  task automatic test_reset_mid_fade();
    logic e;
    logic eb;
    reset_release(2, 8'h01);
    for (int m = 1; m <= 21; m++) begin
      @(posedge clk); #1;
      e = pin_exp(lvl_up(m - 1), m);
      total++;
      if (led_output !== {7'b0, e}) begin
        bad++;
        $display("FAIL midrst_pre_out m=%0d got=%h exp=%h", m, led_output, {7'b0, e});
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (led_output !== 8'h00) begin
      bad++;
      $display("FAIL midrst_out got=%h exp=00", led_output);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    rst_n = 1'b1;
    for (int m = 1; m <= 70; m++) begin
      @(posedge clk); #1;
      e  = pin_exp(lvl_up(m - 1), m);
      eb = (m >= 2) && (lvl_up(m - 1) != 15);
      total++;
      if (led_output !== {7'b0, e}) begin
        bad++;
        $display("FAIL midrst_post_out m=%0d got=%h exp=%h", m, led_output, {7'b0, e});
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL midrst_post_busy m=%0d got=%b exp=%b", m, busy, eb);
      end
    end
  endtask

  task automatic test_parallel();
    logic [7:0] exp_w;
    logic       eb;
    reset_release(2, 8'hA5);
    for (int m = 1; m <= 70; m++) begin
      @(posedge clk); #1;
      exp_w = pin_exp(lvl_up(m - 1), m) ? 8'hA5 : 8'h00;
      eb    = (m >= 2) && (lvl_up(m - 1) != 15);
      total++;
      if (led_output !== exp_w) begin
        bad++;
        $display("FAIL parallel_out m=%0d got=%h exp=%h", m, led_output, exp_w);
      end
      total++;
      if (busy !== eb) begin
        bad++;
        $display("FAIL parallel_busy m=%0d got=%b exp=%b", m, busy, eb);
      end
    end
  endtask

`else
  // ----------------------------------------------------------- direct tests
  task automatic test_reset();
    logic [7:0] exp_w;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (led_output !== 8'h00) begin
        bad++;
        $display("FAIL reset_out c=%0d got=%h exp=00", c, led_output);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      @(posedge clk); #1;
      exp_w = (m >= 3) ? 8'hFF : 8'h00;
      total++;
      if (led_output !== exp_w) begin
        bad++;
        $display("FAIL release_out m=%0d got=%h exp=%h", m, led_output, exp_w);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL release_busy m=%0d got=%b exp=0", m, busy);
      end
    end
  endtask

  task automatic test_direct();
    logic [7:0] pats [0:5];
    logic [7:0] prev;
    logic [7:0] exp_w;
    pats[0] = 8'h3C; pats[1] = 8'hA5; pats[2] = 8'h5A;
    pats[3] = 8'hFF; pats[4] = 8'h00; pats[5] = 8'h81;
    reset_release(2, 8'h00);
    for (int m = 1; m <= 4; m++) begin
      @(posedge clk); #1;
      total++;
      if (led_output !== 8'h00) begin
        bad++;
        $display("FAIL direct_idle m=%0d got=%h exp=00", m, led_output);
      end
    end
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      led_in = pats[i];
      for (int m = 1; m <= 5; m++) begin
        @(posedge clk); #1;
        exp_w = (m >= 3) ? pats[i] : prev;
        total++;
        if (led_output !== exp_w) begin
          bad++;
          $display("FAIL direct_out pat=%h m=%0d got=%h exp=%h", pats[i], m, led_output, exp_w);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL direct_busy pat=%h m=%0d got=%b exp=0", pats[i], m, busy);
        end
      end
      prev = pats[i];
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_w;
    led_in = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (led_output !== 8'hFF) begin
      bad++;
      $display("FAIL midrst_pre_out got=%h exp=ff", led_output);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (led_output !== 8'h00) begin
      bad++;
      $display("FAIL midrst_out got=%h exp=00", led_output);
    end
    rst_n = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      @(posedge clk); #1;
      exp_w = (m >= 3) ? 8'hFF : 8'h00;
      total++;
      if (led_output !== exp_w) begin
        bad++;
        $display("FAIL midrst_post_out m=%0d got=%h exp=%h", m, led_output, exp_w);
      end
    end
  endtask
`endif

  // ------------------------------------------------------------- sequence
  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    led_in = 8'hFF;
    test_reset();
`ifdef LED_FADE_EN
    test_ramp_up();
    test_reversal();
    test_reset_mid_fade();
    test_parallel();
`else
    test_direct();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Output stage between the Nios II system's 8-bit LED PIO export and the board LED pins.
- Consumes the on/off word written by software and drives each pin with a 16-level PWM.
- On each change of the word, each LED ramps its brightness linearly toward fully on or fully off instead of switching at once.
- Software sees no change: it still writes plain on/off bits.

Parameters:
- LEVEL_W, 4: brightness level width. MAX_LEVEL = 2**LEVEL_W-1. The PWM period is 2**LEVEL_W clocks.
- STEP_CYCLES, 50000: clocks per fade step. At 50 MHz this gives 1 ms/step and a 15 ms full fade. Legal values are 2 or greater.
- NUM_LEDS, 8: number of LED channels.

Ports:
- clk  input  1  system clock, same net as the Nios II clk_clk.
- rst_n  input  1  synchronous, active-low reset.
- led_in  input  NUM_LEDS  on/off request word from the PIO export.
- led_output  output  NUM_LEDS  PWM drive to the LED pins, active high.
- busy  output  1  high while any channel's level differs from its target.

Behaviour:
- Clocking and reset:
  - Single clock domain (clk).
  - rst_n is synchronous and active-low: sampled only on the rising edge of clk.
  - While rst_n=0, at every edge: led_req=0, all levels=0, pwm_cnt=0, step_cnt=0, led_output=0, busy=0.
- Input stage:
  - led_in is registered into led_req every cycle. The source is already synchronous to clk.
- PWM counter:
  - pwm_cnt is LEVEL_W bits, increments every cycle, wraps MAX_LEVEL->0.
- Step prescaler:
  - step_cnt counts 0..STEP_CYCLES-1 and wraps.
  - step_tick is asserted for the single cycle in which step_cnt==STEP_CYCLES-1.
- Per-channel level update (only on step_tick):
  - led_req[i]=1 and level<MAX_LEVEL: level+1.
  - led_req[i]=0 and level>0: level-1.
  - Otherwise: hold.
  - Levels saturate at both ends; wrap-around is forbidden.
- Request reversal mid-ramp:
  - The direction reverses from the current level at the next step_tick.
  - No jump and no restart.
- Output:
  - led_output[i] is registered: 1 when level==MAX_LEVEL or level>pwm_cnt, else 0.
  - Level 0: output constant 0. Level MAX_LEVEL: output constant 1. Level k (0<k<MAX): high for k of every 16 cycles.
  - One clock of latency from the level to the pin.
- busy:
  - Registered, equal to the OR over i of (level[i] != (led_req[i] ? MAX_LEVEL : 0)).
  - Deasserts on the cycle after the last channel reaches its target.
- Reset mid-fade:
  - Everything clears at the next edge.
  - After release, the fade restarts from level 0 toward the current led_in.
  - step_cnt starts from 0, so the first step occurs STEP_CYCLES clocks after release.
- Simultaneous requests:
  - Channels are fully independent.
  - All channels ramping in the same direction stay level-aligned.

Optional Feature:
- Macro: LED_FADE_EN.
- Defined: ramp behaviour exactly as above.
- Undefined:
  - The prescaler is not built.
  - The level is set to MAX_LEVEL or 0 directly from led_req every cycle.
  - led_output equals led_in delayed by 3 clocks: led_req register, level register, output register.
  - busy is tied to 0.
  - The PWM compare remains, so levels 0 and MAX still give constant outputs.

Decomposition:
- Package led_drv_pkg:
  - Constants LEVEL_W and MAX_LEVEL.
  - typedef level_t, LEVEL_W bits wide.
  - Helper function target_level(req), returning MAX_LEVEL or 0.
- Sub-module led_fade_channel, one per LED via generate:
  - Inputs: req, step_tick, pwm_cnt.
  - Outputs: pwm_out, at_target.
  - Contains the level register and the compare.
- Top level (led_fade_driver) owns the input register, pwm_cnt, step_cnt and the busy OR.

Test Plan (STEP_CYCLES=4 in simulation):
- Reset: rst_n=0 for 3 cycles with led_in=8'hFF -> led_output=8'h00 and busy=0 throughout. After release, busy=1 by the 3rd cycle.
- Ramp up: led_in 00->01 from rest:
  - Level 0 increments every 4 clocks and reaches 15 after 15 steps, 60 clocks.
  - Duty of led_output[0] measured over each 16-clock window is non-decreasing.
  - From the first window after level 15 is reached, led_output[0]=1 constantly and busy=0.
  - The other 7 bits stay 0.
- Reversal: led_in 01->00 when level reaches 8 -> level goes 8,7,...,0 over 8 steps with no jump. led_output[0] is constant 0 afterwards and busy falls.
- Reset mid-fade: rst_n=0 for 1 cycle at level 5 with led_in=01 -> the next edge gives led_output=00 and busy=0. After release, level climbs 0->15 again.
- Parallel: led_in=8'hA5 -> bits 0, 2, 5 and 7 produce identical waveforms cycle-for-cycle. Bits 1, 3, 4 and 6 stay 0.
- LED_FADE_EN undefined: led_in 00->3C at cycle n -> led_output=8'h3C from cycle n+3 onwards, with no intermediate duty. busy stays 0.
